// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
// Holds the default 640x480@60 timing, the constants derived from it, and the
// coordinate type that the renderers use for DrawX/DrawY.
package vga_timing_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
   localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

   typedef logic [9:0] coord_t;

   // True when an axis of the given total length can be counted in a coord_t.
   function automatic bit fits_coord(input int total);
      return (total >= 2) && (total <= 1024);
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// VGA raster bundle.
// master: driven by vga_timing_gen; slave: read by renderers / connector.
//   pixel_clk  Clk/2 toggle used as the renderers' vga_clk
//   hs, vs     active-low syncs
//   blank      1 = visible pixel
//   sync       composite sync, always 0
//   DrawX/Y    current scan position
//   frame_tick one-Clk pulse at the start of vertical blanking
interface vga_timing_if;
   import vga_timing_pkg::*;

   logic   pixel_clk;
   logic   hs;
   logic   vs;
   logic   blank;
   logic   sync;
   coord_t DrawX;
   coord_t DrawY;
   logic   frame_tick;

   modport master (
      output pixel_clk, hs, vs, blank, sync, DrawX, DrawY, frame_tick
   );

   modport slave (
      input pixel_clk, hs, vs, blank, sync, DrawX, DrawY, frame_tick
   );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 and produces registered sync/active
// qualifiers that always describe the current count.
// Ports:
//   clk, srst  clock and synchronous active-high reset
//   en         advance by one position this cycle
//   count      current position (reset value TOTAL-1 so the first en lands on 0)
//   sync_n     0 while count is inside the sync pulse
//   active     1 while count is inside the visible region
//   wrap       combinational: en is high and count is about to return to 0
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48
) (
   input  logic   clk,
   input  logic   srst,
   input  logic   en,
   output coord_t count,
   output logic   sync_n,
   output logic   active,
   output logic   wrap
);

   localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
   localparam int     SYNC_START = ACTIVE + FP;
   localparam int     SYNC_END   = SYNC_START + SYNC;
   localparam coord_t LAST       = coord_t'(TOTAL - 1);

   coord_t count_reg;
   coord_t count_next;
   logic   sync_n_reg;
   logic   active_reg;

   assign wrap = en && (count_reg == LAST);

   always_comb begin
      count_next = count_reg;
      if (en) begin
         count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
      end
   end

   // Qualifiers are decoded from count_next so they change on the same edge
   // as the count they describe.
   always_ff @(posedge clk) begin
      if (srst) begin
         count_reg  <= LAST;
         sync_n_reg <= 1'b1;
         active_reg <= 1'b0;
      end else if (en) begin
         count_reg  <= count_next;
         sync_n_reg <= !((int'(count_next) >= SYNC_START) && (int'(count_next) < SYNC_END));
         active_reg <= int'(count_next) < ACTIVE;
      end
   end

   assign count  = count_reg;
   assign sync_n = sync_n_reg;
   assign active = active_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator.
// Derives the pixel clock from Clk, scans DrawX/DrawY, and produces the
// syncs, the visible-area qualifier and a per-frame tick for the renderers.
// Ports:
//   Clk    50 MHz system clock (only clock)
//   Reset  synchronous active-high reset
//   vga    vga_timing_if master: pixel_clk, hs, vs, blank, sync, DrawX,
//          DrawY, frame_tick
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic         Clk,
   input  logic         Reset,
   vga_timing_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (!fits_coord(H_TOTAL) || !fits_coord(V_TOTAL)) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 2..1024");
   end

   logic   pixel_clk_reg;
   logic   pix_en;
   logic   v_en;
   logic   frame_tick_reg;
   coord_t h_count;
   coord_t v_count;
   logic   h_sync_n;
   logic   v_sync_n;
   logic   h_active;
   logic   v_active;
   logic   h_wrap;

   // Counters advance on the edge where pixel_clk falls, so the scan position
   // is stable across the renderers' rising pixel_clk edge.
   assign pix_en = pixel_clk_reg;
   assign v_en   = pix_en & h_wrap;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pixel_clk_reg <= 1'b0;
      end else begin
         pixel_clk_reg <= !pixel_clk_reg;
      end
   end

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk    (Clk),
      .srst   (Reset),
      .en     (pix_en),
      .count  (h_count),
      .sync_n (h_sync_n),
      .active (h_active),
      .wrap   (h_wrap)
   );

   // End of frame is implied by the horizontal wrap at the last line, so the
   // vertical wrap has no consumer here.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk    (Clk),
      .srst   (Reset),
      .en     (v_en),
      .count  (v_count),
      .sync_n (v_sync_n),
      .active (v_active),
      .wrap   ()
   );

   // Raised on the edge that moves the scan to (0, V_ACTIVE); pix_en is never
   // high on two consecutive Clk cycles, so the pulse is one Clk wide.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_tick_reg <= 1'b0;
      end else begin
         frame_tick_reg <= v_en && (v_count == coord_t'(V_ACTIVE - 1));
      end
   end

   assign vga.pixel_clk  = pixel_clk_reg;
   assign vga.hs         = h_sync_n;
   assign vga.vs         = v_sync_n;
   assign vga.blank      = h_active & v_active;
   assign vga.sync       = 1'b0;
   assign vga.DrawX      = h_count;
   assign vga.DrawY      = v_count;
   assign vga.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance for reset and line
// timing, and a shrunken instance (32x20 total) for whole-frame behaviour.
// A per-pixel reference model pushes expected outputs each Clk; they are
// popped and compared against both instances one time unit after the edge.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam int SH_A = 16, SH_F = 4, SH_S = 6, SH_B = 6;
   localparam int SV_A = 12, SV_F = 2, SV_S = 2, SV_B = 4;
   localparam int SH_T = SH_A + SH_F + SH_S + SH_B;
   localparam int SV_T = SV_A + SV_F + SV_S + SV_B;
   localparam int S_FRAME_CLK = 2 * SH_T * SV_T;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #10 clk = ~clk;

   vga_timing_if f_if ();
   vga_timing_if s_if ();

   vga_timing_gen u_full (
      .Clk   (clk),
      .Reset (rst),
      .vga   (f_if)
   );

   vga_timing_gen #(
      .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
      .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B)
   ) u_small (
      .Clk   (clk),
      .Reset (rst),
      .vga   (s_if)
   );

   typedef struct packed {
      logic       pclk;
      logic       hs;
      logic       vs;
      logic       blank;
      logic       sync;
      logic [9:0] x;
      logic [9:0] y;
      logic       tick;
   } obs_t;

   typedef struct {
      int ha, hf, hsw, hb;
      int va, vf, vsw, vb;
      bit pclk;
      int x, y;
      bit tick;
   } model_t;

   model_t m_full;
   model_t m_small;
   obs_t   q_full[$];
   obs_t   q_small[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit meas_line = 0;
   int line_hs = 0, line_blank = 0;
   int win_left = 0, w_blank = 0, w_vs = 0, w_ticks = 0;
   int last_tick_cyc = -1, max_x = 0, max_y = 0;
   bit prev_tick = 0;

   function automatic model_t model_step(input model_t md, input bit r);
      model_t n = md;
      int ht = md.ha + md.hf + md.hsw + md.hb;
      int vt = md.va + md.vf + md.vsw + md.vb;
      n.tick = 0;
      if (r) begin
         n.pclk = 0;
         n.x = ht - 1;
         n.y = vt - 1;
      end else begin
         if (md.pclk) begin
            if (md.x == ht - 1) begin
               n.x = 0;
               if (md.y == vt - 1) begin
                  n.y = 0;
               end else begin
                  n.y = md.y + 1;
                  if (n.y == md.va) n.tick = 1;
               end
            end else begin
               n.x = md.x + 1;
            end
         end
         n.pclk = !md.pclk;
      end
      return n;
   endfunction

   function automatic obs_t model_out(input model_t md);
      obs_t o;
      o.pclk  = md.pclk;
      o.hs    = !(md.x >= md.ha + md.hf && md.x < md.ha + md.hf + md.hsw);
      o.vs    = !(md.y >= md.va + md.vf && md.y < md.va + md.vf + md.vsw);
      o.blank = (md.x < md.ha) && (md.y < md.va);
      o.sync  = 1'b0;
      o.x     = 10'(md.x);
      o.y     = 10'(md.y);
      o.tick  = md.tick;
      return o;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic run(input int n);
      obs_t exp_o, obs_o;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         m_full  = model_step(m_full, rst);
         m_small = model_step(m_small, rst);
         q_full.push_back(model_out(m_full));
         q_small.push_back(model_out(m_small));
         #1;
         cyc++;
         exp_o = q_full.pop_front();
         obs_o = {f_if.pixel_clk, f_if.hs, f_if.vs, f_if.blank, f_if.sync,
                  f_if.DrawX, f_if.DrawY, f_if.frame_tick};
         checks++;
         assert (obs_o === exp_o) else begin
            errors++;
            $error("FAIL full_sb cyc=%0d observed=%h expected=%h", cyc, obs_o, exp_o);
         end
         exp_o = q_small.pop_front();
         obs_o = {s_if.pixel_clk, s_if.hs, s_if.vs, s_if.blank, s_if.sync,
                  s_if.DrawX, s_if.DrawY, s_if.frame_tick};
         checks++;
         assert (obs_o === exp_o) else begin
            errors++;
            $error("FAIL small_sb cyc=%0d observed=%h expected=%h", cyc, obs_o, exp_o);
         end
         if (meas_line && f_if.DrawY == 10'd0) begin
            if (!f_if.hs) line_hs++;
            if (f_if.blank) line_blank++;
         end
         if (win_left > 0) begin
            win_left--;
            if (s_if.blank) w_blank++;
            if (!s_if.vs) w_vs++;
            if (int'(s_if.DrawX) > max_x) max_x = int'(s_if.DrawX);
            if (int'(s_if.DrawY) > max_y) max_y = int'(s_if.DrawY);
            if (s_if.frame_tick) begin
               w_ticks++;
               if (last_tick_cyc >= 0) check("tick_period", cyc - last_tick_cyc, S_FRAME_CLK);
               last_tick_cyc = cyc;
            end
         end
         if (prev_tick) check("tick_width", int'(s_if.frame_tick), 0);
         prev_tick = s_if.frame_tick;
      end
   endtask

   initial begin
      int guard;
      m_full  = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 0, 0};
      m_small = '{SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 0, 0, 0, 0};

      // Reset held for 5 Clk.
      rst = 1'b1;
      run(5);
      check("rst_drawx", int'(f_if.DrawX), 799);
      check("rst_drawy", int'(f_if.DrawY), 524);
      check("rst_hs", int'(f_if.hs), 1);
      check("rst_vs", int'(f_if.vs), 1);
      check("rst_blank", int'(f_if.blank), 0);
      check("rst_pclk", int'(f_if.pixel_clk), 0);
      check("rst_tick", int'(f_if.frame_tick), 0);

      // Release: first Clk only raises pixel_clk, second lands on (0,0).
      rst = 1'b0;
      meas_line = 1;
      run(1);
      check("rel_pclk", int'(f_if.pixel_clk), 1);
      check("rel_hold_x", int'(f_if.DrawX), 799);
      run(1);
      check("start_x", int'(f_if.DrawX), 0);
      check("start_y", int'(f_if.DrawY), 0);
      check("start_blank", int'(f_if.blank), 1);

      // Two full lines plus a little: line-0 hs/blank widths in Clk.
      run(3298);
      meas_line = 0;
      check("line_hs_clk", line_hs, 192);
      check("line_blank_clk", line_blank, 1280);
      check("after_lines_y", int'(f_if.DrawY), 2);
      check("after_lines_x", int'(f_if.DrawX), 49);

      // Mid-frame reset on the small instance at (10,5).
      guard = 0;
      while (!(s_if.DrawX == 10'd10 && s_if.DrawY == 10'd5) && guard < 3000) begin
         run(1);
         guard++;
      end
      check("reach_10_5", int'(s_if.DrawX == 10'd10 && s_if.DrawY == 10'd5), 1);
      rst = 1'b1;
      run(1);
      check("mid_rst_x", int'(s_if.DrawX), SH_T - 1);
      check("mid_rst_y", int'(s_if.DrawY), SV_T - 1);
      check("mid_rst_blank", int'(s_if.blank), 0);
      check("mid_rst_pclk", int'(s_if.pixel_clk), 0);
      check("mid_rst_full_x", int'(f_if.DrawX), 799);

      // Restart and observe exactly three frames.
      rst = 1'b0;
      win_left = 1 + 3 * S_FRAME_CLK;
      run(2);
      check("restart_x", int'(s_if.DrawX), 0);
      check("restart_y", int'(s_if.DrawY), 0);
      check("restart_blank", int'(s_if.blank), 1);
      run(3 * S_FRAME_CLK - 1);
      check("frames_blank_clk", w_blank, 3 * SH_A * SV_A * 2);
      check("frames_vs_clk", w_vs, 3 * SV_S * SH_T * 2);
      check("frames_ticks", w_ticks, 3);
      check("max_drawx", max_x, SH_T - 1);
      check("max_drawy", max_y, SV_T - 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
